wb_ram_arbiter: RTL and testbench

- Two-master, one-slave Wishbone B4 classic arbiter that shares the core's RAM Wishbone port between the instruction bus (m0) and the data bus (m1).
- Sits between the core's bus masters and the wb_m2s_ram_*/wb_s2m_ram_* slave signals.
- Round-robin arbitration, with the grant locked for a whole cycle (cyc high, including CTI bursts).
- A bus watchdog terminates hung slave accesses with ERR.

---
 rtl/wb_arb_pkg.sv | 15 +
 rtl/wb_watchdog.sv | 32 +++
 rtl/wb_ram_arbiter.sv | 156 +++++++++++++++
 tb/tb_wb_ram_arbiter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the two-master Wishbone RAM arbiter.
// CTI encodings are provided for masters and benches that build bursts.
package wb_arb_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_GNT0,
      ARB_GNT1
   } arb_state_t;

   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_INCR    = 3'b010;
   localparam logic [2:0] CTI_EOB     = 3'b111;

endpackage

// File: rtl/wb_watchdog.sv
// Bus watchdog: counts cycles a strobe waits for termination.
// Fires for one cycle when the limit is hit, unless the slave terminates in that same cycle.
module wb_watchdog #(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned CNT_W          = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic i_active,
   input  logic i_done,
   input  logic i_clr,
   output logic o_fire
);

   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

   logic [CNT_W-1:0] r_cnt;

   // A termination in the limit cycle wins over the timeout.
   assign o_fire = (TIMEOUT_CYCLES != 0) && i_active && !i_done && (r_cnt == LIMIT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if ((TIMEOUT_CYCLES == 0) || i_clr || !i_active || i_done || o_fire) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/wb_ram_arbiter.sv
// Round-robin Wishbone B4 classic arbiter sharing the RAM port between ibus (m0) and dbus (m1).
// The grant is registered and held for the full cyc; slave responses pass through combinationally.
module wb_ram_arbiter
   import wb_arb_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned CNT_W          = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_m0_cyc,
   input  logic        i_m0_stb,
   input  logic        i_m0_we,
   input  logic [29:0] i_m0_adr,
   input  logic [31:0] i_m0_dat,
   input  logic [3:0]  i_m0_sel,
   input  logic [2:0]  i_m0_cti,
   input  logic [1:0]  i_m0_bte,
   output logic [31:0] o_m0_rdt,
   output logic        o_m0_ack,
   output logic        o_m0_err,
   input  logic        i_m1_cyc,
   input  logic        i_m1_stb,
   input  logic        i_m1_we,
   input  logic [29:0] i_m1_adr,
   input  logic [31:0] i_m1_dat,
   input  logic [3:0]  i_m1_sel,
   input  logic [2:0]  i_m1_cti,
   input  logic [1:0]  i_m1_bte,
   output logic [31:0] o_m1_rdt,
   output logic        o_m1_ack,
   output logic        o_m1_err,
   output logic        o_s_cyc,
   output logic        o_s_stb,
   output logic        o_s_we,
   output logic [29:0] o_s_adr,
   output logic [31:0] o_s_dat,
   output logic [3:0]  o_s_sel,
   output logic [2:0]  o_s_cti,
   output logic [1:0]  o_s_bte,
   input  logic [31:0] i_s_rdt,
   input  logic        i_s_ack,
   input  logic        i_s_err,
   output logic        o_timeout
);

   arb_state_t r_state;
   arb_state_t w_next;
   logic       r_last;
   logic       w_last_next;
   logic       w_active;
   logic       w_fire;

   assign o_m0_rdt  = i_s_rdt;
   assign o_m1_rdt  = i_s_rdt;
   assign o_timeout = w_fire;

   assign w_active = ((r_state == ARB_GNT0) && i_m0_cyc && i_m0_stb) ||
                     ((r_state == ARB_GNT1) && i_m1_cyc && i_m1_stb);

   wb_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .CNT_W          (CNT_W)
   ) u_watchdog (
      .clk      (clk),
      .rst      (rst),
      .i_active (w_active),
      .i_done   (i_s_ack | i_s_err),
      .i_clr    (r_state != w_next),
      .o_fire   (w_fire)
   );

   // r_last remembers who was served most recently; reset to 1 so m0 wins the first tie.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ARB_IDLE;
         r_last  <= 1'b1;
      end else begin
         r_state <= w_next;
         r_last  <= w_last_next;
      end
   end

   always_comb begin
      w_next      = r_state;
      w_last_next = r_last;
      case (r_state)
         ARB_IDLE: begin
            if (i_m0_cyc && i_m1_cyc) begin
               w_next = r_last ? ARB_GNT0 : ARB_GNT1;
            end else if (i_m0_cyc) begin
               w_next = ARB_GNT0;
            end else if (i_m1_cyc) begin
               w_next = ARB_GNT1;
            end
         end
         ARB_GNT0: begin
            if (!i_m0_cyc) begin
               w_last_next = 1'b0;
               w_next      = i_m1_cyc ? ARB_GNT1 : ARB_IDLE;
            end
         end
         ARB_GNT1: begin
            if (!i_m1_cyc) begin
               w_last_next = 1'b1;
               w_next      = i_m0_cyc ? ARB_GNT0 : ARB_IDLE;
            end
         end
         default: w_next = ARB_IDLE;
      endcase
   end

   // A watchdog fire suppresses cyc/stb toward the slave for that one cycle.
   always_comb begin
      o_s_cyc  = 1'b0;
      o_s_stb  = 1'b0;
      o_s_we   = 1'b0;
      o_s_adr  = '0;
      o_s_dat  = '0;
      o_s_sel  = '0;
      o_s_cti  = '0;
      o_s_bte  = '0;
      o_m0_ack = 1'b0;
      o_m0_err = 1'b0;
      o_m1_ack = 1'b0;
      o_m1_err = 1'b0;
      case (r_state)
         ARB_GNT0: begin
            o_s_cyc  = i_m0_cyc & ~w_fire;
            o_s_stb  = i_m0_stb & ~w_fire;
            o_s_we   = i_m0_we;
            o_s_adr  = i_m0_adr;
            o_s_dat  = i_m0_dat;
            o_s_sel  = i_m0_sel;
            o_s_cti  = i_m0_cti;
            o_s_bte  = i_m0_bte;
            o_m0_ack = i_s_ack;
            o_m0_err = i_s_err | w_fire;
         end
         ARB_GNT1: begin
            o_s_cyc  = i_m1_cyc & ~w_fire;
            o_s_stb  = i_m1_stb & ~w_fire;
            o_s_we   = i_m1_we;
            o_s_adr  = i_m1_adr;
            o_s_dat  = i_m1_dat;
            o_s_sel  = i_m1_sel;
            o_s_cti  = i_m1_cti;
            o_s_bte  = i_m1_bte;
            o_m1_ack = i_s_ack;
            o_m1_err = i_s_err | w_fire;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_wb_ram_arbiter.sv
// Directed self-checking bench for wb_ram_arbiter with an 8-cycle watchdog.
// Inputs change and outputs are sampled 1-2 time units after each rising edge.
module tb_wb_ram_arbiter;
   import wb_arb_pkg::*;

   logic        clk;
   logic        rst;
   logic        m0Cyc, m0Stb, m0We;
   logic [29:0] m0Adr;
   logic [31:0] m0Dat;
   logic [3:0]  m0Sel;
   logic [2:0]  m0Cti;
   logic [1:0]  m0Bte;
   logic [31:0] m0Rdt;
   logic        m0Ack, m0Err;
   logic        m1Cyc, m1Stb, m1We;
   logic [29:0] m1Adr;
   logic [31:0] m1Dat;
   logic [3:0]  m1Sel;
   logic [2:0]  m1Cti;
   logic [1:0]  m1Bte;
   logic [31:0] m1Rdt;
   logic        m1Ack, m1Err;
   logic        sCyc, sStb, sWe;
   logic [29:0] sAdr;
   logic [31:0] sDat;
   logic [3:0]  sSel;
   logic [2:0]  sCti;
   logic [1:0]  sBte;
   logic [31:0] sRdt;
   logic        sAck, sErr;
   logic        timeout;

   int nCompared;
   int nMismatched;

   wb_ram_arbiter #(
      .TIMEOUT_CYCLES (8),
      .CNT_W          (4)
   ) dut (
      .clk (clk), .rst (rst),
      .i_m0_cyc (m0Cyc), .i_m0_stb (m0Stb), .i_m0_we (m0We), .i_m0_adr (m0Adr),
      .i_m0_dat (m0Dat), .i_m0_sel (m0Sel), .i_m0_cti (m0Cti), .i_m0_bte (m0Bte),
      .o_m0_rdt (m0Rdt), .o_m0_ack (m0Ack), .o_m0_err (m0Err),
      .i_m1_cyc (m1Cyc), .i_m1_stb (m1Stb), .i_m1_we (m1We), .i_m1_adr (m1Adr),
      .i_m1_dat (m1Dat), .i_m1_sel (m1Sel), .i_m1_cti (m1Cti), .i_m1_bte (m1Bte),
      .o_m1_rdt (m1Rdt), .o_m1_ack (m1Ack), .o_m1_err (m1Err),
      .o_s_cyc (sCyc), .o_s_stb (sStb), .o_s_we (sWe), .o_s_adr (sAdr),
      .o_s_dat (sDat), .o_s_sel (sSel), .o_s_cti (sCti), .o_s_bte (sBte),
      .i_s_rdt (sRdt), .i_s_ack (sAck), .i_s_err (sErr),
      .o_timeout (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      nCompared++;
      if (observed !== expected) begin
         nMismatched++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic applyStimulus(input int m, input logic cyc, input logic stb, input logic [29:0] adr,
                                input logic [2:0] cti);
      if (m == 0) begin
         m0Cyc = cyc; m0Stb = stb; m0Adr = adr; m0Cti = cti;
      end else begin
         m1Cyc = cyc; m1Stb = stb; m1Adr = adr; m1Cti = cti;
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   initial begin
      nCompared   = 0;
      nMismatched = 0;
      rst = 1'b1;
      m0We = 1'b0; m0Dat = 32'h0; m0Sel = 4'hF; m0Bte = 2'b00;
      m1We = 1'b1; m1Dat = 32'hCAFE0001; m1Sel = 4'hF; m1Bte = 2'b00;
      applyStimulus(0, 1'b0, 1'b0, 30'h0, CTI_CLASSIC);
      applyStimulus(1, 1'b0, 1'b0, 30'h0, CTI_CLASSIC);
      sRdt = 32'h0; sAck = 1'b0; sErr = 1'b0;
      #2;
      checkOutput("reset_s_cyc", 32'(sCyc), 32'h0);
      checkOutput("reset_timeout", 32'(timeout), 32'h0);
      checkOutput("reset_m0_ack", 32'(m0Ack), 32'h0);
      doReset();

      $display("[TB] single m0 read");
      applyStimulus(0, 1'b1, 1'b1, 30'h100, CTI_CLASSIC);
      #1 checkOutput("rd_latency_s_cyc", 32'(sCyc), 32'h0);
      step();
      checkOutput("rd_s_cyc", 32'(sCyc), 32'h1);
      checkOutput("rd_s_adr", 32'(sAdr), 32'h100);
      checkOutput("rd_s_we", 32'(sWe), 32'h0);
      step();
      checkOutput("rd_no_early_ack", 32'(m0Ack), 32'h0);
      step();
      sAck = 1'b1; sRdt = 32'hDEADBEEF;
      #1;
      checkOutput("rd_m0_ack", 32'(m0Ack), 32'h1);
      checkOutput("rd_m0_rdt", m0Rdt, 32'hDEADBEEF);
      checkOutput("rd_m1_ack", 32'(m1Ack), 32'h0);
      step();
      sAck = 1'b0;
      applyStimulus(0, 1'b0, 1'b0, 30'h0, CTI_CLASSIC);
      step();
      checkOutput("rd_idle_s_cyc", 32'(sCyc), 32'h0);

      $display("[TB] tie after reset");
      doReset();
      applyStimulus(0, 1'b1, 1'b1, 30'h10, CTI_CLASSIC);
      applyStimulus(1, 1'b1, 1'b1, 30'h20, CTI_CLASSIC);
      step();
      checkOutput("tie1_s_adr", 32'(sAdr), 32'h10);
      checkOutput("tie1_m1_ack_blocked", 32'(m1Ack), 32'h0);
      applyStimulus(0, 1'b0, 1'b0, 30'h0, CTI_CLASSIC);
      step();
      checkOutput("tie_handover_s_cyc", 32'(sCyc), 32'h1);
      checkOutput("tie_handover_s_adr", 32'(sAdr), 32'h20);
      applyStimulus(1, 1'b0, 1'b0, 30'h0, CTI_CLASSIC);
      step();
      applyStimulus(0, 1'b1, 1'b1, 30'h10, CTI_CLASSIC);
      applyStimulus(1, 1'b1, 1'b1, 30'h20, CTI_CLASSIC);
      step();
      checkOutput("tie2_s_adr", 32'(sAdr), 32'h10);
      applyStimulus(0, 1'b0, 1'b0, 30'h0, CTI_CLASSIC);
      applyStimulus(1, 1'b0, 1'b0, 30'h0, CTI_CLASSIC);
      step();

      $display("[TB] burst lock");
      applyStimulus(1, 1'b1, 1'b1, 30'h200, CTI_INCR);
      step();
      applyStimulus(0, 1'b1, 1'b1, 30'h100, CTI_CLASSIC);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1, 1'b1, 1'b1, 30'(32'h200 + i), (i == 3) ? CTI_EOB : CTI_INCR);
         sAck = 1'b1;
         #1;
         checkOutput($sformatf("burst_adr%0d", i), 32'(sAdr), 32'h200 + i);
         checkOutput($sformatf("burst_m1_ack%0d", i), 32'(m1Ack), 32'h1);
         checkOutput($sformatf("burst_m0_ack%0d", i), 32'(m0Ack), 32'h0);
         step();
      end
      sAck = 1'b0;
      checkOutput("burst_s_cti_eob", 32'(sCti), 32'(CTI_EOB));
      applyStimulus(1, 1'b0, 1'b0, 30'h0, CTI_CLASSIC);
      step();
      checkOutput("burst_m0_gnt_cyc", 32'(sCyc), 32'h1);
      checkOutput("burst_m0_gnt_adr", 32'(sAdr), 32'h100);
      applyStimulus(0, 1'b0, 1'b0, 30'h0, CTI_CLASSIC);
      step();

      $display("[TB] watchdog timeout");
      applyStimulus(0, 1'b1, 1'b1, 30'h300, CTI_CLASSIC);
      step();
      for (int k = 0; k < 8; k++) begin
         checkOutput($sformatf("wd_pre_timeout%0d", k), 32'(timeout), 32'h0);
         checkOutput($sformatf("wd_pre_stb%0d", k), 32'(sStb), 32'h1);
         step();
      end
      checkOutput("wd_timeout", 32'(timeout), 32'h1);
      checkOutput("wd_m0_err", 32'(m0Err), 32'h1);
      checkOutput("wd_s_stb_forced", 32'(sStb), 32'h0);
      checkOutput("wd_s_cyc_forced", 32'(sCyc), 32'h0);
      step();
      checkOutput("wd_post_timeout", 32'(timeout), 32'h0);
      checkOutput("wd_post_err", 32'(m0Err), 32'h0);
      checkOutput("wd_grant_kept", 32'(sStb), 32'h1);
      applyStimulus(0, 1'b0, 1'b0, 30'h0, CTI_CLASSIC);
      step();

      $display("[TB] ack vs timeout race");
      applyStimulus(0, 1'b1, 1'b1, 30'h304, CTI_CLASSIC);
      step();
      for (int k = 0; k < 8; k++) step();
      sAck = 1'b1; sRdt = 32'h12345678;
      #1;
      checkOutput("race_m0_ack", 32'(m0Ack), 32'h1);
      checkOutput("race_m0_err", 32'(m0Err), 32'h0);
      checkOutput("race_timeout", 32'(timeout), 32'h0);
      checkOutput("race_s_stb", 32'(sStb), 32'h1);
      step();
      sAck = 1'b0;
      applyStimulus(0, 1'b0, 1'b0, 30'h0, CTI_CLASSIC);
      step();

      $display("[TB] reset mid-access");
      applyStimulus(1, 1'b1, 1'b1, 30'h400, CTI_CLASSIC);
      step();
      sAck = 1'b1;
      #1;
      checkOutput("rst_pre_m1_ack", 32'(m1Ack), 32'h1);
      rst = 1'b1;
      #1;
      checkOutput("rst_s_cyc", 32'(sCyc), 32'h0);
      checkOutput("rst_m1_ack", 32'(m1Ack), 32'h0);
      sAck = 1'b0;
      step();
      rst = 1'b0;
      #1;
      checkOutput("rst_regrant_latency", 32'(sCyc), 32'h0);
      step();
      checkOutput("rst_regrant_cyc", 32'(sCyc), 32'h1);
      checkOutput("rst_regrant_adr", 32'(sAdr), 32'h400);
      applyStimulus(1, 1'b0, 1'b0, 30'h0, CTI_CLASSIC);
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
